// File: rtl/mem_stall_sequencer_pkg.sv
// Shared state encodings and helpers for the memory-stall pipeline sequencer.
package mem_stall_sequencer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    // Width needed to count 0..timeout-1 wait cycles.
    function automatic int wait_cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/mem_stall_sequencer_sat_counter.sv
// Saturating up-counter with synchronous reset; usable for any performance counter.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/mem_stall_sequencer.sv
// Freezes/clears the FD, DE, EM and MWB pipeline banks around stalled memory
// accesses and branch flushes, with a watchdog and a stall-cycle counter.
module mem_stall_sequencer
    import mem_stall_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             global_rst,
    input  logic             mem_req_valid,
    input  logic             mem_stall,
    input  logic             mem_done,
    input  logic             branch_flush,
    output logic             freeze_FD,
    output logic             freeze_DE,
    output logic             freeze_EM,
    output logic             freeze_MWB,
    output logic             clr_FD,
    output logic             clr_DE,
    output logic             clr_MWB,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WC_W = wait_cnt_width(TIMEOUT);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);

    logic [1:0]       state, state_nxt;
    logic [WC_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic             pend_flush, pend_flush_nxt;
    logic             stall_en;
    logic [CNT_W-1:0] stall_q;

    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        pend_flush_nxt = pend_flush;
        stall_en       = 1'b0;
        freeze_FD      = 1'b0;
        freeze_DE      = 1'b0;
        freeze_EM      = 1'b0;
        freeze_MWB     = 1'b0;
        clr_FD         = 1'b0;
        clr_DE         = 1'b0;
        clr_MWB        = 1'b0;
        busy           = 1'b0;
        err            = 1'b0;

        case (state)
            ST_IDLE: begin
                if (mem_req_valid && mem_stall && !mem_done) begin
                    state_nxt = ST_WAIT;
                    freeze_FD = 1'b1;
                    freeze_DE = 1'b1;
                    freeze_EM = 1'b1;
                    clr_MWB   = 1'b1;
                    stall_en  = 1'b1;
                end else begin
                    clr_FD = branch_flush;
                    clr_DE = branch_flush;
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (mem_done) begin
                    // Release: MWB captures read data, deferred flush lands now.
                    state_nxt      = ST_IDLE;
                    clr_FD         = pend_flush | branch_flush;
                    clr_DE         = pend_flush | branch_flush;
                    wait_cnt_nxt   = '0;
                    pend_flush_nxt = 1'b0;
                end else begin
                    freeze_FD      = 1'b1;
                    freeze_DE      = 1'b1;
                    freeze_EM      = 1'b1;
                    clr_MWB        = 1'b1;
                    stall_en       = 1'b1;
                    wait_cnt_nxt   = wait_cnt + 1'b1;
                    pend_flush_nxt = pend_flush | branch_flush;
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                freeze_FD  = 1'b1;
                freeze_DE  = 1'b1;
                freeze_EM  = 1'b1;
                freeze_MWB = 1'b1;
                busy       = 1'b1;
                err        = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Pipeline flops are reset directly by global_rst; keep controls quiet.
        if (global_rst) begin
            stall_en   = 1'b0;
            freeze_FD  = 1'b0;
            freeze_DE  = 1'b0;
            freeze_EM  = 1'b0;
            freeze_MWB = 1'b0;
            clr_FD     = 1'b0;
            clr_DE     = 1'b0;
            clr_MWB    = 1'b0;
            busy       = 1'b0;
            err        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (global_rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            pend_flush <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            pend_flush <= pend_flush_nxt;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (global_rst),
        .en  (stall_en),
        .q   (stall_q)
    );

    assign stall_cycles = global_rst ? '0 : stall_q;

endmodule
